// File: rtl/enemy_event_detector_if.sv
// rtl/enemy_event_detector_if.sv - enemy-mover event bundle between detector and movers
//
// Purpose: groups the per-enemy event signals the detector produces for the
//          enemy move/collision instances.
// Signals:
//   changeDirection  [2:0]       enemy i touched a tower in the previous frame
//   dodgeBullet      [2:0]       enemy i is threatened by the player bullet
//   shotCollision    [2:0][2:0]  per enemy; bit0 = killed, bits[2:1] = 0
//   bulletHit                    1-cycle pulse: the bullet must be removed
// Modports: master = detector (drives), slave = movers (observe).

interface enemy_event_detector_if;
    logic [2:0]      changeDirection;
    logic [2:0]      dodgeBullet;
    logic [2:0][2:0] shotCollision;
    logic            bulletHit;

    modport master (
        output changeDirection,
        output dodgeBullet,
        output shotCollision,
        output bulletHit
    );

    modport slave (
        input changeDirection,
        input dodgeBullet,
        input shotCollision,
        input bulletHit
    );
endinterface

// File: rtl/enemy_event_detector.sv
// rtl/enemy_event_detector.sv - per-frame enemy/tower, enemy/bullet overlap and bullet-threat detector
//
// Purpose: accumulates pixel overlaps over a frame, commits them at startOfFrame,
//          keeps sticky kill flags and (optionally) sweeps the three enemies for
//          bullet proximity once per frame.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   startOfFrame               1-cycle frame strobe (commit point)
//   pause                      freeze: no accumulation, no commit
//   restart_loc                clears the sticky kill flags
//   enemyDR[2:0], towerDR,
//   bulletDR                   draw requests of the current pixel
//   bulletActive, bulletX/Y    player bullet state (top-left)
//   enemyX/enemyY[2:0]         enemy top-left positions
//   ev (master)                changeDirection, dodgeBullet, shotCollision, bulletHit
// Configuration:
//   ENEMY_DODGE_EN defined   -> dodge FSM builds dodgeBullet (valid 4 cycles after SOF)
//   ENEMY_DODGE_EN undefined -> dodgeBullet tied to 3'b000

module enemy_event_detector #(
    parameter int N_ENEMIES = 3,
    parameter int ENEMY_W   = 32,
    parameter int BULLET_W  = 8,
    parameter int DODGE_X   = 40,
    parameter int DODGE_Y   = 96
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic                       pause,
    input  logic                       restart_loc,
    input  logic [N_ENEMIES-1:0]       enemyDR,
    input  logic                       towerDR,
    input  logic                       bulletDR,
    input  logic                       bulletActive,
    input  logic [10:0]                bulletX,
    input  logic [10:0]                bulletY,
    input  logic [N_ENEMIES-1:0][10:0] enemyX,
    input  logic [N_ENEMIES-1:0][10:0] enemyY,
    enemy_event_detector_if.master     ev
);

    logic                 commit;
    logic [N_ENEMIES-1:0] tow_acc;
    logic [N_ENEMIES-1:0] hit_acc;
    logic [N_ENEMIES-1:0] killed;
    logic [N_ENEMIES-1:0] change_dir;
    logic                 bullet_hit;
    logic [N_ENEMIES-1:0] dead_mask;
    logic [N_ENEMIES-1:0] tow_pix;
    logic [N_ENEMIES-1:0] hit_pix;

    assign commit = startOfFrame & ~pause;

    // A pixel in the commit cycle belongs to the new frame, so it must already
    // see the kills that this commit is about to record.
    assign dead_mask = killed | (commit ? hit_acc : '0);
    assign tow_pix   = enemyDR & {N_ENEMIES{towerDR}}  & ~dead_mask;
    assign hit_pix   = enemyDR & {N_ENEMIES{bulletDR}} & ~dead_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tow_acc    <= '0;
            hit_acc    <= '0;
            killed     <= '0;
            change_dir <= '0;
            bullet_hit <= 1'b0;
        end else begin
            // Only enemies alive before this commit can consume the bullet.
            bullet_hit <= commit & (|(hit_acc & ~killed));
            if (commit) begin
                change_dir <= tow_acc;
                tow_acc    <= tow_pix;
                hit_acc    <= hit_pix;
            end else if (!pause) begin
                tow_acc    <= tow_acc | tow_pix;
                hit_acc    <= hit_acc | hit_pix;
            end
            if (restart_loc) begin
                killed <= '0;
            end else if (commit) begin
                killed <= killed | hit_acc;
            end
        end
    end

    assign ev.changeDirection = change_dir;
    assign ev.bulletHit       = bullet_hit;

    always_comb begin
        ev.shotCollision = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            ev.shotCollision[i] = {2'b00, killed[i]};
        end
    end

`ifdef ENEMY_DODGE_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK0,
        S_CHK1,
        S_CHK2,
        S_DONE
    } state_t;

    state_t               state;
    logic [1:0]           sel;
    logic [N_ENEMIES-1:0] threat;
    logic [N_ENEMIES-1:0] dodge_q;
    logic [11:0]          ex;
    logic [11:0]          bx;
    logic signed [11:0]   dx_s;
    logic [11:0]          dx_abs;
    logic [11:0]          dy_u;
    logic                 threat_now;

    always_comb begin
        sel = 2'd0;
        case (state)
            S_CHK1:  sel = 2'd1;
            S_CHK2:  sel = 2'd2;
            default: sel = 2'd0;
        endcase
    end

    // 12-bit centres keep a sprite near X=2047 from wrapping onto the left edge.
    always_comb begin
        ex         = {1'b0, enemyX[sel]} + 12'(ENEMY_W / 2);
        bx         = {1'b0, bulletX} + 12'(BULLET_W / 2);
        dx_s       = $signed(bx - ex);
        dx_abs     = dx_s[11] ? 12'(-dx_s) : 12'(dx_s);
        dy_u       = {1'b0, bulletY} - ({1'b0, enemyY[sel]} + 12'(ENEMY_W));
        // dy_u[11] set means the bullet is above the enemy's bottom edge.
        threat_now = bulletActive & ~killed[sel] & (dx_abs <= 12'(DODGE_X))
                   & ~dy_u[11] & (dy_u <= 12'(DODGE_Y));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            threat  <= '0;
            dodge_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit) begin
                        threat <= '0;
                        state  <= S_CHK0;
                    end
                end
                S_CHK0: begin
                    threat[sel] <= threat_now;
                    state       <= S_CHK1;
                end
                S_CHK1: begin
                    threat[sel] <= threat_now;
                    state       <= S_CHK2;
                end
                S_CHK2: begin
                    threat[sel] <= threat_now;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    dodge_q <= threat;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ev.dodgeBullet = dodge_q;
`else
    logic unused_dodge_inputs;
    assign unused_dodge_inputs = ^{bulletActive, bulletX, bulletY, enemyX, enemyY,
                                   BULLET_W, DODGE_X, DODGE_Y};
    assign ev.dodgeBullet = '0;
`endif

endmodule

// File: tb/tb_enemy_event_detector.sv
// tb/tb_enemy_event_detector.sv - randomized self-checking bench for enemy_event_detector

module tb_enemy_event_detector;

`ifdef ENEMY_DODGE_EN
    localparam bit DODGE_ON = 1'b1;
`else
    localparam bit DODGE_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            startOfFrame;
    logic            pause;
    logic            restart_loc;
    logic [2:0]      enemyDR;
    logic            towerDR;
    logic            bulletDR;
    logic            bulletActive;
    logic [10:0]     bulletX;
    logic [10:0]     bulletY;
    logic [2:0][10:0] enemyX;
    logic [2:0][10:0] enemyY;

    enemy_event_detector_if ev ();

    enemy_event_detector dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .pause        (pause),
        .restart_loc  (restart_loc),
        .enemyDR      (enemyDR),
        .towerDR      (towerDR),
        .bulletDR     (bulletDR),
        .bulletActive (bulletActive),
        .bulletX      (bulletX),
        .bulletY      (bulletY),
        .enemyX       (enemyX),
        .enemyY       (enemyY),
        .ev           (ev)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame-level bookkeeping of the event rules.
    logic [2:0] m_tow, m_hit, m_killed, m_cd, m_dodge, m_pend;
    bit         m_pulse;
    int         m_sweep;

    task automatic model_reset();
        m_tow = '0; m_hit = '0; m_killed = '0; m_cd = '0;
        m_dodge = '0; m_pend = '0; m_pulse = 1'b0; m_sweep = 0;
    endtask

    function automatic bit threat_of(input int i, input logic [2:0] k);
        int ex, bx, dx, dy;
        ex = int'(enemyX[i]) + 16;
        bx = int'(bulletX) + 4;
        dx = (bx > ex) ? bx - ex : ex - bx;
        dy = int'(bulletY) - (int'(enemyY[i]) + 32);
        return bulletActive && !k[i] && dx <= 40 && dy >= 0 && dy <= 96;
    endfunction

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic model_step();
        logic [2:0] k;
        bit commit;
        commit  = startOfFrame && !pause;
        m_pulse = 1'b0;
        k       = m_killed;
        if (commit) begin
            m_cd    = m_tow;
            m_pulse = (m_hit & ~m_killed) != 3'b000;
            k       = m_killed | m_hit;
            m_tow   = '0;
            m_hit   = '0;
        end
        if (!pause) begin
            m_tow |= enemyDR & {3{towerDR}} & ~k;
            m_hit |= enemyDR & {3{bulletDR}} & ~k;
        end
        if (restart_loc) k = '0;
        if (m_sweep > 0) begin
            m_sweep--;
            if (m_sweep == 0) m_dodge = m_pend;
        end else if (commit && DODGE_ON) begin
            m_sweep = 4;
            for (int i = 0; i < 3; i++) m_pend[i] = threat_of(i, k);
        end
        m_killed = k;
    endtask

    task automatic check_all();
        logic [8:0] sc;
        for (int i = 0; i < 3; i++) sc[i*3 +: 3] = {2'b00, m_killed[i]};
        check_eq("changeDirection", 32'(ev.changeDirection), 32'(m_cd));
        check_eq("bulletHit",       32'(ev.bulletHit),       32'(m_pulse));
        check_eq("shotCollision",   32'(ev.shotCollision),   32'(sc));
        check_eq("dodgeBullet",     32'(ev.dodgeBullet),     32'(m_dodge));
    endtask

    task automatic drive(input bit sof, input bit pz, input bit rl,
                         input logic [2:0] e, input bit t, input bit b);
        startOfFrame = sof; pause = pz; restart_loc = rl;
        enemyDR = e; towerDR = t; bulletDR = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 3'b000, 0, 0);
    endtask

    task automatic place(input int e0x, input int e0y, input int x, input int y, input bit act);
        enemyX[0] = 11'(e0x); enemyY[0] = 11'(e0y);
        enemyX[1] = 11'd600;  enemyY[1] = 11'd600;
        enemyX[2] = 11'd900;  enemyY[2] = 11'd900;
        bulletX = 11'(x); bulletY = 11'(y); bulletActive = act;
    endtask

    task automatic random_frame();
        int k, v;
        k = $urandom_range(0, 2);
        for (int i = 0; i < 3; i++) begin
            enemyX[i] = 11'($urandom_range(0, 1900));
            enemyY[i] = 11'($urandom_range(0, 1800));
        end
        v = int'(enemyX[k]) + 12 + $urandom_range(0, 120) - 60;
        bulletX = 11'((v < 0) ? 0 : v);
        bulletY = 11'(int'(enemyY[k]) + 32 + $urandom_range(0, 140) - 30);
        bulletActive = ($urandom_range(0, 3) != 0);
        drive(1, $urandom_range(0, 4) == 0, 0, 3'b000, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, $urandom_range(0, 3) == 0, 0,
                  ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end
        if ($urandom_range(0, 3) == 0) drive(0, 0, 1, 3'b000, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        startOfFrame = 0; pause = 0; restart_loc = 0;
        enemyDR = '0; towerDR = 0; bulletDR = 0;
        place(100, 100, 1000, 1500, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_changeDirection", 32'(ev.changeDirection), 32'd0);
        check_eq("rst_bulletHit",       32'(ev.bulletHit),       32'd0);
        check_eq("rst_shotCollision",   32'(ev.shotCollision),   32'd0);
        check_eq("rst_dodgeBullet",     32'(ev.dodgeBullet),     32'd0);
        reset = 1'b0;
        idle(6);

        // tower touch by enemy 1 in one frame, held for exactly the next frame
        drive(1, 0, 0, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b010, 1, 0);
        idle(3);
        drive(1, 0, 0, 3'b000, 0, 0);
        check_eq("cd_set", 32'(ev.changeDirection), 32'b010);
        idle(4);
        drive(1, 0, 0, 3'b000, 0, 0);
        check_eq("cd_clr", 32'(ev.changeDirection), 32'b000);

        // enemy 0 shot: sticky kill, single bulletHit pulse, restart clears
        drive(0, 0, 0, 3'b001, 0, 1);
        idle(2);
        drive(1, 0, 0, 3'b000, 0, 0);
        check_eq("shot_kill", 32'(ev.shotCollision[0]), 32'b001);
        check_eq("shot_pulse", 32'(ev.bulletHit), 32'd1);
        idle(1);
        check_eq("shot_pulse_end", 32'(ev.bulletHit), 32'd0);
        for (int f = 0; f < 5; f++) begin
            drive(1, 0, 0, 3'b000, 0, 0);
            drive(0, 0, 0, 3'b001, 1, 1);
            idle(3);
        end
        check_eq("shot_sticky", 32'(ev.shotCollision[0]), 32'b001);
        drive(0, 0, 1, 3'b000, 0, 0);
        check_eq("shot_restart", 32'(ev.shotCollision[0]), 32'b000);
        idle(2);

        // dodge threat, then bullet too far right
        place(200, 100, 212, 150, 1'b1);
        drive(1, 0, 0, 3'b000, 0, 0);
        idle(6);
        check_eq("dodge_near", 32'(ev.dodgeBullet), DODGE_ON ? 32'b001 : 32'b000);
        place(200, 100, 300, 150, 1'b1);
        drive(1, 0, 0, 3'b000, 0, 0);
        idle(6);
        check_eq("dodge_far", 32'(ev.dodgeBullet), 32'b000);

        // right-edge enemy must not alias onto a left-edge bullet
        place(2040, 100, 4, 150, 1'b1);
        drive(1, 0, 0, 3'b000, 0, 0);
        idle(6);
        check_eq("dodge_edge", 32'(ev.dodgeBullet), 32'b000);
        // bullet above the enemy bottom edge
        place(200, 100, 212, 120, 1'b1);
        drive(1, 0, 0, 3'b000, 0, 0);
        idle(6);

        // startOfFrame during CHK1 must not restart the sweep
        place(200, 100, 212, 150, 1'b1);
        drive(1, 0, 0, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b000, 0, 0);
        drive(1, 0, 0, 3'b000, 0, 0);
        idle(6);

        // reset in the middle of a sweep
        place(200, 100, 300, 150, 1'b1);
        drive(1, 0, 0, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b000, 0, 0);
        #2 reset = 1'b1;
        #1 check_eq("rst_mid_dodge", 32'(ev.dodgeBullet), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // pause across SOF freezes everything, next unpaused SOF commits
        drive(0, 0, 0, 3'b100, 1, 1);
        drive(0, 1, 0, 3'b010, 1, 1);
        drive(1, 1, 0, 3'b000, 0, 0);
        check_eq("pause_cd", 32'(ev.changeDirection), 32'b000);
        idle(3);
        drive(1, 0, 0, 3'b000, 0, 0);
        check_eq("unpause_cd", 32'(ev.changeDirection), 32'b100);
        check_eq("unpause_hit", 32'(ev.bulletHit), 32'd1);
        idle(5);

        // two enemies in one frame: one pulse
        drive(0, 0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b011, 0, 1);
        drive(1, 0, 0, 3'b000, 0, 0);
        check_eq("double_kill", 32'(ev.shotCollision), 32'b000_001_001 | 32'(ev.shotCollision[2]) << 6);
        idle(1);
        check_eq("double_pulse_end", 32'(ev.bulletHit), 32'd0);
        idle(4);
        drive(0, 0, 1, 3'b000, 0, 0);

        for (int f = 0; f < 80; f++) random_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
